// File: rtl/vga_sync_gen.sv
// VGA raw timing generator: free-running column/row counters plus sync and
// active-video flags delayed to line up with the downstream RAM read.
module vga_sync_gen #(
    parameter int H_SYNC   = 120,
    parameter int H_BACK   = 64,
    parameter int H_ACTIVE = 800,
    parameter int H_FRONT  = 56,
    parameter int V_SYNC   = 6,
    parameter int V_BACK   = 23,
    parameter int V_ACTIVE = 600,
    parameter int V_FRONT  = 37,
    parameter bit SYNC_POL = 1'b1,
    parameter int PIPE_DLY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [10:0] c1,
    output logic [10:0] c2,
    output logic        hsync,
    output logic        vsync,
    output logic        ready,
    output logic        frame_start,
    output logic        line_start
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_SYNC_E = 11'(H_SYNC);
    localparam logic [10:0] V_SYNC_E = 11'(V_SYNC);
    localparam logic [10:0] H_ACT_LO = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_ACT_HI = 11'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [10:0] V_ACT_LO = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] V_ACT_HI = 11'(V_SYNC + V_BACK + V_ACTIVE);

    generate
        if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_total
            $error("vga_sync_gen: H_TOTAL/V_TOTAL must fit 11-bit counters");
        end
        if (PIPE_DLY < 1 || PIPE_DLY > 4) begin : g_bad_dly
            $error("vga_sync_gen: PIPE_DLY must be in 1..4");
        end
    endgenerate

    logic h_last;
    logic hs_raw, vs_raw, act_raw;

    // Each stage holds {hs, vs, act} in asserted-high form; polarity applied at the tail.
    logic [PIPE_DLY-1:0][2:0] dly_pipe;

    assign h_last = (c1 == H_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c1 <= '0;
            c2 <= '0;
        end else begin
            c1 <= h_last ? 11'd0 : c1 + 11'd1;
            if (h_last)
                c2 <= (c2 == V_LAST) ? 11'd0 : c2 + 11'd1;
        end
    end

    assign hs_raw  = (c1 < H_SYNC_E);
    assign vs_raw  = (c2 < V_SYNC_E);
    assign act_raw = (c1 >= H_ACT_LO) && (c1 < H_ACT_HI) &&
                     (c2 >= V_ACT_LO) && (c2 < V_ACT_HI);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_pipe <= '0;
        end else begin
            dly_pipe[0] <= {hs_raw, vs_raw, act_raw};
            for (int i = 1; i < PIPE_DLY; i++)
                dly_pipe[i] <= dly_pipe[i-1];
        end
    end

    assign hsync = dly_pipe[PIPE_DLY-1][2] ~^ SYNC_POL;
    assign vsync = dly_pipe[PIPE_DLY-1][1] ~^ SYNC_POL;
    assign ready = dly_pipe[PIPE_DLY-1][0];

    assign line_start  = (c1 == 11'd0);
    assign frame_start = (c1 == 11'd0) && (c2 == 11'd0);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: per-cycle check of three parameterisations against
// an arithmetic position model, plus hand-computed literal expectations.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // A: default 800x600 timing; S: tiny timing (19x11) for whole-frame checks;
    // P: default timing with active-low sync and single-stage delay.
    logic [10:0] a_c1, a_c2, s_c1, s_c2, p_c1, p_c2;
    logic a_hs, a_vs, a_rdy, a_fs, a_ls;
    logic s_hs, s_vs, s_rdy, s_fs, s_ls;
    logic p_hs, p_vs, p_rdy, p_fs, p_ls;

    vga_sync_gen u_a (
        .clk(clk), .rst_n(rst_n), .c1(a_c1), .c2(a_c2), .hsync(a_hs), .vsync(a_vs),
        .ready(a_rdy), .frame_start(a_fs), .line_start(a_ls)
    );

    vga_sync_gen #(
        .H_SYNC(4), .H_BACK(3), .H_ACTIVE(10), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(2), .V_ACTIVE(5),  .V_FRONT(2),
        .SYNC_POL(1'b1), .PIPE_DLY(2)
    ) u_s (
        .clk(clk), .rst_n(rst_n), .c1(s_c1), .c2(s_c2), .hsync(s_hs), .vsync(s_vs),
        .ready(s_rdy), .frame_start(s_fs), .line_start(s_ls)
    );

    vga_sync_gen #(.SYNC_POL(1'b0), .PIPE_DLY(1)) u_p (
        .clk(clk), .rst_n(rst_n), .c1(p_c1), .c2(p_c2), .hsync(p_hs), .vsync(p_vs),
        .ready(p_rdy), .frame_start(p_fs), .line_start(p_ls)
    );

    int total = 0;
    int bad   = 0;

    // Edges seen since reset was released; the whole model is a function of this.
    int n;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n <= 0;
        else        n <= n + 1;
    end

    typedef struct packed {
        logic [10:0] c1;
        logic [10:0] c2;
        logic        hsy;
        logic        vsy;
        logic        rdy;
        logic        fs;
        logic        ls;
    } exp_t;

    function automatic exp_t model(int t, int hs, int hb, int ha, int hf,
                                   int vs, int vb, int va, int vf, bit pol, int d);
        exp_t e;
        int ht = hs + hb + ha + hf;
        int vt = vs + vb + va + vf;
        int p  = t - d;
        int x, y;
        e.c1 = 11'(t % ht);
        e.c2 = 11'((t / ht) % vt);
        e.ls = ((t % ht) == 0);
        e.fs = ((t % (ht * vt)) == 0);
        if (p < 0) begin
            e.hsy = ~pol;
            e.vsy = ~pol;
            e.rdy = 1'b0;
        end else begin
            x = p % ht;
            y = (p / ht) % vt;
            e.hsy = (x < hs) ? pol : ~pol;
            e.vsy = (y < vs) ? pol : ~pol;
            e.rdy = (x >= hs + hb) && (x < hs + hb + ha) &&
                    (y >= vs + vb) && (y < vs + vb + va);
        end
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t n=%0d)", name, act, exp, $time, n);
        end
    endtask

    task automatic chk_inst(input string tag, input exp_t e, input logic [10:0] c1,
                            input logic [10:0] c2, input logic hs, input logic vs,
                            input logic rdy, input logic fs, input logic ls);
        chk({tag, ".c1"}, int'(c1), int'(e.c1));
        chk({tag, ".c2"}, int'(c2), int'(e.c2));
        chk({tag, ".hsync"}, int'(hs), int'(e.hsy));
        chk({tag, ".vsync"}, int'(vs), int'(e.vsy));
        chk({tag, ".ready"}, int'(rdy), int'(e.rdy));
        chk({tag, ".frame_start"}, int'(fs), int'(e.fs));
        chk({tag, ".line_start"}, int'(ls), int'(e.ls));
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk_inst("A", model(n, 120, 64, 800, 56, 6, 23, 600, 37, 1'b1, 2),
                     a_c1, a_c2, a_hs, a_vs, a_rdy, a_fs, a_ls);
            chk_inst("S", model(n, 4, 3, 10, 2, 2, 2, 5, 2, 1'b1, 2),
                     s_c1, s_c2, s_hs, s_vs, s_rdy, s_fs, s_ls);
            chk_inst("P", model(n, 120, 64, 800, 56, 6, 23, 600, 37, 1'b0, 1),
                     p_c1, p_c2, p_hs, p_vs, p_rdy, p_fs, p_ls);
        end
    end

    // Per-line / per-frame tallies checked against hand-computed totals.
    initial begin
        int a_ls_n = 0, a_hcnt = 0, a_rcnt = 0, a_row = 0;
        int p_lcnt = 0, s_fs_n = 0, s_vcnt = 0, s_rcnt = 0;
        bit a_seen = 0, p_seen = 0, s_seen = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                a_seen = 0; p_seen = 0; s_seen = 0;
            end else begin
                if (a_ls) begin
                    if (a_seen) begin
                        chk("A.line_period", n - a_ls_n, 1040);
                        chk("A.hsync_per_line", a_hcnt, 120);
                        chk("A.ready_per_line", a_rcnt, (a_row >= 29 && a_row <= 628) ? 800 : 0);
                    end
                    a_seen = 1; a_ls_n = n; a_row = (n / 1040) % 666;
                    a_hcnt = 0; a_rcnt = 0;
                end
                a_hcnt += int'(a_hs);
                a_rcnt += int'(a_rdy);

                if (p_ls) begin
                    if (p_seen) chk("P.hsync_low_per_line", p_lcnt, 120);
                    p_seen = 1; p_lcnt = 0;
                end
                p_lcnt += int'(!p_hs);

                if (s_fs) begin
                    if (s_seen) begin
                        chk("S.frame_period", n - s_fs_n, 209);
                        chk("S.vsync_per_frame", s_vcnt, 38);
                        chk("S.ready_per_frame", s_rcnt, 50);
                    end
                    s_seen = 1; s_fs_n = n; s_vcnt = 0; s_rcnt = 0;
                end
                s_vcnt += int'(s_vs);
                s_rcnt += int'(s_rdy);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("rst.A.c1", int'(a_c1), 0);
        chk("rst.A.c2", int'(a_c2), 0);
        chk("rst.A.hsync", int'(a_hs), 0);
        chk("rst.A.vsync", int'(a_vs), 0);
        chk("rst.A.ready", int'(a_rdy), 0);
        chk("rst.A.frame_start", int'(a_fs), 1);
        chk("rst.P.hsync", int'(p_hs), 1);

        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel1.A.c1", int'(a_c1), 1);
        chk("rel1.A.hsync", int'(a_hs), 0);
        chk("rel1.P.hsync", int'(p_hs), 0);
        @(posedge clk); #1;
        chk("rel2.A.hsync", int'(a_hs), 1);

        // Tiny frame is 19*11 = 209 clocks: check the joint wrap.
        repeat (206) @(posedge clk); #1;
        chk("wrap.S.c1", int'(s_c1), 18);
        chk("wrap.S.c2", int'(s_c2), 10);
        chk("wrap.S.frame_start", int'(s_fs), 0);
        @(posedge clk); #1;
        chk("wrap1.S.c1", int'(s_c1), 0);
        chk("wrap1.S.c2", int'(s_c2), 0);
        chk("wrap1.S.frame_start", int'(s_fs), 1);
        chk("wrap1.S.line_start", int'(s_ls), 1);

        // Run into an active row of A and stop at c1=500, c2=33.
        repeat (33 * 1040 + 500 - 209) @(posedge clk); #1;
        chk("mid.A.c1", int'(a_c1), 500);
        chk("mid.A.c2", int'(a_c2), 33);
        chk("mid.A.ready", int'(a_rdy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.A.c1", int'(a_c1), 0);
        chk("midrst.A.c2", int'(a_c2), 0);
        chk("midrst.A.ready", int'(a_rdy), 0);
        chk("midrst.A.hsync", int'(a_hs), 0);
        chk("midrst.A.vsync", int'(a_vs), 0);
        chk("midrst.A.frame_start", int'(a_fs), 1);

        repeat (5) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rerel1.A.c1", int'(a_c1), 1);
        chk("rerel1.A.ready", int'(a_rdy), 0);
        @(posedge clk); #1;
        chk("rerel2.A.hsync", int'(a_hs), 1);
        repeat (3 * 1040) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
